muldiv_hilo_unit: RTL and testbench

- Execute-stage consumer of the 5-bit alucontrol code produced by the instruction decoder.
- Executes MULT/MULTU (2-cycle) and DIV/DIVU (34-cycle radix-2 restoring) and owns the architectural HI/LO registers.
- Serves MTHI/MTLO writes and raises a pipeline stall while a multi-cycle operation holds the E stage.
- Control codes are the `*_CONTROL` macros in defines2.vh: MULT, MULTU, DIV, DIVU, MTHI, MTLO.

---
 rtl/muldiv_hilo_if.sv | 37 +++
 rtl/muldiv_hilo_unit.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_if.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_if
// Groups the E-stage request and HI/LO result signals of the multiply/divide
// unit into one bundle.
//   valid_i       E-stage instruction valid
//   alucontrol_i  decoded 5-bit ALU control code
//   src_a_i       rs value (dividend / multiplicand / MTHI/MTLO data)
//   src_b_i       rt value (divisor / multiplier)
//   flush_i       cancels the operation in flight
//   stall_o       hold the E stage and everything upstream
//   hi_o / lo_o   architectural HI / LO registers
//   busy_o        unit is not idle
// master: pipeline side, slave: muldiv_hilo_unit.
// ---------------------------------------------------------------------------
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [4:0]       alucontrol_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             flush_i;
    logic             stall_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;

    modport master (
        output valid_i, alucontrol_i, src_a_i, src_b_i, flush_i,
        input  stall_o, hi_o, lo_o, busy_o
    );

    modport slave (
        input  valid_i, alucontrol_i, src_a_i, src_b_i, flush_i,
        output stall_o, hi_o, lo_o, busy_o
    );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// ---------------------------------------------------------------------------
// muldiv_hilo_unit
// Execute-stage multiply/divide unit owning the HI/LO registers.
// MULT/MULTU finish in one stall cycle, DIV/DIVU use a radix-2 restoring
// divider (WIDTH iterations). MTHI/MTLO write HI/LO without stalling.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  muldiv_hilo_if slave (request, stall, HI/LO, busy)
// ---------------------------------------------------------------------------
module muldiv_hilo_unit #(
    parameter int         WIDTH         = 32,
    parameter logic [4:0] MULT_CONTROL  = 5'b11000,
    parameter logic [4:0] MULTU_CONTROL = 5'b11001,
    parameter logic [4:0] DIV_CONTROL   = 5'b11010,
    parameter logic [4:0] DIVU_CONTROL  = 5'b11011,
    parameter logic [4:0] MTHI_CONTROL  = 5'b11100,
    parameter logic [4:0] MTLO_CONTROL  = 5'b11101
) (
    input logic          clk,
    input logic          rst,
    muldiv_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic             w_stall;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_isDiv;
    logic             r_negQuo;
    logic             r_negRem;

    logic             w_issue;
    logic             w_isMul;
    logic             w_isDiv;
    logic             w_signed;
    logic             w_bZero;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [2*WIDTH-1:0] w_aExt;
    logic [2*WIDTH-1:0] w_bExt;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_quoFinal;
    logic [WIDTH-1:0] w_remFinal;

    assign w_issue  = (r_state == IDLE) && bus.valid_i && !bus.flush_i;
    assign w_isMul  = (bus.alucontrol_i == MULT_CONTROL) || (bus.alucontrol_i == MULTU_CONTROL);
    assign w_isDiv  = (bus.alucontrol_i == DIV_CONTROL)  || (bus.alucontrol_i == DIVU_CONTROL);
    assign w_signed = (bus.alucontrol_i == MULT_CONTROL) || (bus.alucontrol_i == DIV_CONTROL);
    assign w_bZero  = (bus.src_b_i == '0);

    assign w_absA = (w_signed && bus.src_a_i[WIDTH-1]) ? -bus.src_a_i : bus.src_a_i;
    assign w_absB = (w_signed && bus.src_b_i[WIDTH-1]) ? -bus.src_b_i : bus.src_b_i;

    // Sign- or zero-extend to the full product width so one unsigned
    // multiplier covers both MULT and MULTU.
    assign w_aExt    = w_signed ? {{WIDTH{bus.src_a_i[WIDTH-1]}}, bus.src_a_i}
                                : {{WIDTH{1'b0}}, bus.src_a_i};
    assign w_bExt    = w_signed ? {{WIDTH{bus.src_b_i[WIDTH-1]}}, bus.src_b_i}
                                : {{WIDTH{1'b0}}, bus.src_b_i};
    assign w_product = w_aExt * w_bExt;

    // One restoring step: shift the next dividend bit into the remainder,
    // the top bit of w_trial is the borrow of the trial subtraction.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};

    assign w_quoFinal = r_negQuo ? -r_quo : r_quo;
    assign w_remFinal = r_negRem ? -r_rem : r_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue && w_isMul) begin
                    w_stateNext = DONE;
                    w_stall     = 1'b1;
                end else if (w_issue && w_isDiv) begin
                    w_stateNext = DIV;
                    w_stall     = 1'b1;
                end
            end
            MUL: begin
                w_stateNext = DONE;
                w_stall     = 1'b1;
            end
            DIV: begin
                w_stall = 1'b1;
                // The step taken this cycle brings the counter to zero.
                if (r_count == CW'(1)) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        if (bus.flush_i) begin
            w_stateNext = IDLE;
            w_stall     = 1'b0;
        end
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    // A zero divisor latches the raw dividend with no sign flags: the
    // restoring loop then yields quotient all-ones and remainder = src_a,
    // which is exactly the required divide-by-zero result for DIV and DIVU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
        end else begin
            if (w_issue && w_isMul) begin
                {r_rem, r_quo} <= w_product;
                r_isDiv        <= 1'b0;
                r_negQuo       <= 1'b0;
                r_negRem       <= 1'b0;
            end else if (w_issue && w_isDiv) begin
                r_isDiv <= 1'b1;
                r_rem   <= '0;
                r_count <= CW'(WIDTH);
                if (w_bZero) begin
                    r_quo     <= bus.src_a_i;
                    r_divisor <= '0;
                    r_negQuo  <= 1'b0;
                    r_negRem  <= 1'b0;
                end else begin
                    r_quo     <= w_absA;
                    r_divisor <= w_absB;
                    r_negQuo  <= w_signed && (bus.src_a_i[WIDTH-1] ^ bus.src_b_i[WIDTH-1]);
                    r_negRem  <= w_signed && bus.src_a_i[WIDTH-1];
                end
            end else if (r_state == DIV) begin
                r_count <= r_count - CW'(1);
                if (!w_trial[WIDTH]) begin
                    r_rem <= w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_shifted[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                end
            end

            if (w_issue && (bus.alucontrol_i == MTHI_CONTROL)) begin
                r_hi <= bus.src_a_i;
            end
            if (w_issue && (bus.alucontrol_i == MTLO_CONTROL)) begin
                r_lo <= bus.src_a_i;
            end
            if ((r_state == DONE) && !bus.flush_i) begin
                if (r_isDiv) begin
                    r_hi <= w_remFinal;
                    r_lo <= w_quoFinal;
                end else begin
                    r_hi <= r_rem;
                    r_lo <= r_quo;
                end
            end
        end
    end

    assign bus.stall_o = w_stall;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
    assign bus.busy_o  = (r_state != IDLE);
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_hilo_unit
// Drives directed and random instruction sequences into muldiv_hilo_unit and
// compares stall/busy/HI/LO on every cycle against a timeline model built from
// the instruction latencies and plain-arithmetic results.
// ---------------------------------------------------------------------------
module tb_muldiv_hilo_unit;
    localparam int         WIDTH   = 32;
    localparam logic [4:0] C_MULT  = 5'b11000;
    localparam logic [4:0] C_MULTU = 5'b11001;
    localparam logic [4:0] C_DIV   = 5'b11010;
    localparam logic [4:0] C_DIVU  = 5'b11011;
    localparam logic [4:0] C_MTHI  = 5'b11100;
    localparam logic [4:0] C_MTLO  = 5'b11101;
    localparam logic [4:0] C_OTHER = 5'b00010;

    logic clock;
    logic reset;

    muldiv_hilo_if #(.WIDTH(WIDTH)) bus ();

    muldiv_hilo_unit #(
        .WIDTH(WIDTH),
        .MULT_CONTROL(C_MULT), .MULTU_CONTROL(C_MULTU),
        .DIV_CONTROL(C_DIV),   .DIVU_CONTROL(C_DIVU),
        .MTHI_CONTROL(C_MTHI), .MTLO_CONTROL(C_MTLO)
    ) dut (
        .clk(clock),
        .rst(reset),
        .bus(bus)
    );

    int          errorCount = 0;
    int          checkCount = 0;
    int          stallCycles = 0;
    logic        checkEn = 1'b0;
    logic        expStall = 1'b0;
    logic        expBusy = 1'b0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("stall_o", {31'b0, bus.stall_o}, {31'b0, expStall});
            checkOutput("busy_o",  {31'b0, bus.busy_o},  {31'b0, expBusy});
            checkOutput("hi_o", bus.hi_o, expHi);
            checkOutput("lo_o", bus.lo_o, expLo);
        end
        if (bus.stall_o) stallCycles++;
    end

    // Architectural result of one multiply/divide instruction.
    task automatic modelResult(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        int          da;
        int          db;
        hi = mHi;
        lo = mLo;
        if (ctrl == C_MULT) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
        end else if (ctrl == C_MULTU) begin
            p  = {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (ctrl == C_DIVU || ctrl == C_DIV) begin
            if (b == 32'd0) begin
                hi = a;
                lo = 32'hFFFFFFFF;
            end else if (ctrl == C_DIVU) begin
                hi = a % b;
                lo = a / b;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                hi = 32'd0;
                lo = 32'h80000000;
            end else begin
                da = $signed(a);
                db = $signed(b);
                hi = da % db;
                lo = da / db;
            end
        end
    endtask

    // One cycle: drive inputs just after the edge and load the default
    // expectations (idle unit, HI/LO from the model).
    task automatic applyStimulus(input logic v, input logic [4:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl);
        @(posedge clock);
        #1;
        bus.valid_i      = v;
        bus.alucontrol_i = ctrl;
        bus.src_a_i      = a;
        bus.src_b_i      = b;
        bus.flush_i      = fl;
        expStall = 1'b0;
        expBusy  = 1'b0;
        expHi    = mHi;
        expLo    = mLo;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // Issue one instruction and hold it on the bus while the unit stalls.
    // flushAt: cycle index (0 = issue cycle) carrying flush_i, -1 for none.
    task automatic runOp(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b, input int flushAt);
        int          lat;
        logic [31:0] rh;
        logic [31:0] rl;
        lat = (ctrl == C_MULT || ctrl == C_MULTU) ? 1 :
              (ctrl == C_DIV  || ctrl == C_DIVU)  ? WIDTH + 1 : 0;
        applyStimulus(1'b1, ctrl, a, b, flushAt == 0);
        expStall = (lat != 0) && (flushAt != 0);
        if (flushAt == 0) return;
        if (ctrl == C_MTHI) mHi = a;
        if (ctrl == C_MTLO) mLo = a;
        if (lat == 0) return;
        modelResult(ctrl, a, b, rh, rl);
        for (int k = 1; k <= lat; k++) begin
            applyStimulus(1'b1, ctrl, a, b, k == flushAt);
            expBusy  = 1'b1;
            expStall = (k < lat) && (k != flushAt);
            if (k == flushAt) return;
        end
        mHi = rh;
        mLo = rl;
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4, 5:    return 32'($urandom_range(0, 200));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] h;
        logic [31:0] l;
        logic [4:0]  codes [7];
        logic [4:0]  ctrl;
        int          fAt;

        codes = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_MTHI, C_MTLO, C_OTHER};
        reset = 1'b1;
        bus.valid_i = 1'b0; bus.alucontrol_i = '0; bus.src_a_i = '0; bus.src_b_i = '0; bus.flush_i = 1'b0;

        // Pin the reference model with hand-computed results.
        modelResult(C_MULT, 32'hFFFFFFFF, 32'd2, h, l);
        checkOutput("model MULT hi", h, 32'hFFFFFFFF); checkOutput("model MULT lo", l, 32'hFFFFFFFE);
        modelResult(C_MULTU, 32'hFFFFFFFF, 32'd2, h, l);
        checkOutput("model MULTU hi", h, 32'h00000001); checkOutput("model MULTU lo", l, 32'hFFFFFFFE);
        modelResult(C_DIV, 32'hFFFFFFF9, 32'd2, h, l);
        checkOutput("model DIV hi", h, 32'hFFFFFFFF); checkOutput("model DIV lo", l, 32'hFFFFFFFD);
        modelResult(C_DIVU, 32'd100, 32'd7, h, l);
        checkOutput("model DIVU hi", h, 32'd2); checkOutput("model DIVU lo", l, 32'd14);
        modelResult(C_DIV, 32'h80000000, 32'hFFFFFFFF, h, l);
        checkOutput("model DIV ovf hi", h, 32'd0); checkOutput("model DIV ovf lo", l, 32'h80000000);
        modelResult(C_DIVU, 32'h1234, 32'd0, h, l);
        checkOutput("model DIVU0 hi", h, 32'h1234); checkOutput("model DIVU0 lo", l, 32'hFFFFFFFF);

        // Reset state, then release reset.
        idle(1);
        checkEn = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);

        // Multiply: one stall cycle.
        stallCycles = 0;
        runOp(C_MULT, 32'hFFFFFFFF, 32'd2, -1);
        idle(1);
        checkOutput("MULT stall cycles", 32'(stallCycles), 32'd1);
        checkOutput("MULT hi", bus.hi_o, 32'hFFFFFFFF);
        checkOutput("MULT lo", bus.lo_o, 32'hFFFFFFFE);
        runOp(C_MULTU, 32'hFFFFFFFF, 32'd2, -1);
        idle(1);
        checkOutput("MULTU hi", bus.hi_o, 32'h00000001);
        checkOutput("MULTU lo", bus.lo_o, 32'hFFFFFFFE);

        // Divide: 33 stall cycles, signed fix-up, overflow, divide by zero.
        stallCycles = 0;
        runOp(C_DIV, 32'hFFFFFFF9, 32'd2, -1);
        idle(1);
        checkOutput("DIV stall cycles", 32'(stallCycles), 32'd33);
        checkOutput("DIV hi", bus.hi_o, 32'hFFFFFFFF);
        checkOutput("DIV lo", bus.lo_o, 32'hFFFFFFFD);
        runOp(C_DIVU, 32'd100, 32'd7, -1);
        idle(1);
        checkOutput("DIVU hi", bus.hi_o, 32'd2);
        checkOutput("DIVU lo", bus.lo_o, 32'd14);
        runOp(C_DIV, 32'h80000000, 32'hFFFFFFFF, -1);
        idle(1);
        checkOutput("DIV ovf hi", bus.hi_o, 32'd0);
        checkOutput("DIV ovf lo", bus.lo_o, 32'h80000000);
        runOp(C_DIVU, 32'h1234, 32'd0, -1);
        idle(1);
        checkOutput("DIVU0 hi", bus.hi_o, 32'h1234);
        checkOutput("DIVU0 lo", bus.lo_o, 32'hFFFFFFFF);

        // Flush on the 10th DIV cycle leaves HI/LO untouched.
        runOp(C_MTHI, 32'h5A5A5A5A, 32'd0, -1);
        runOp(C_MTLO, 32'h5A5A5A5A, 32'd0, -1);
        runOp(C_DIVU, 32'd100, 32'd7, 10);
        idle(2);
        checkOutput("flush hi", bus.hi_o, 32'h5A5A5A5A);
        checkOutput("flush lo", bus.lo_o, 32'h5A5A5A5A);

        // Flush in the DONE cycle suppresses the write.
        runOp(C_DIVU, 32'd50, 32'd5, WIDTH + 1);
        idle(1);
        checkOutput("flush DONE lo", bus.lo_o, 32'h5A5A5A5A);

        // Back-to-back MTHI/MTLO then an immediate MULT.
        runOp(C_MTHI, 32'hDEADBEEF, 32'd0, -1);
        runOp(C_MTLO, 32'h0BADF00D, 32'd0, -1);
        checkOutput("MTHI hi", bus.hi_o, 32'hDEADBEEF);
        runOp(C_MULT, 32'd3, 32'd5, -1);
        checkOutput("MTLO lo", bus.lo_o, 32'h0BADF00D);
        idle(1);

        // Reset in the 5th DIV cycle.
        applyStimulus(1'b1, C_DIV, 32'd1000, 32'd3, 1'b0);
        expStall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, C_DIV, 32'd1000, 32'd3, 1'b0);
            expStall = 1'b1;
            expBusy  = 1'b1;
        end
        #1;
        reset = 1'b1;
        bus.valid_i = 1'b0;
        #1;
        checkOutput("rst hi", bus.hi_o, 32'd0);
        checkOutput("rst lo", bus.lo_o, 32'd0);
        checkOutput("rst stall", {31'b0, bus.stall_o}, 32'd0);
        checkOutput("rst busy", {31'b0, bus.busy_o}, 32'd0);
        mHi = '0; mLo = '0;
        expHi = '0; expLo = '0; expStall = 1'b0; expBusy = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(1);
        runOp(C_DIVU, 32'd9, 32'd3, -1);
        idle(1);
        checkOutput("post-rst DIVU hi", bus.hi_o, 32'd0);
        checkOutput("post-rst DIVU lo", bus.lo_o, 32'd3);

        // Random instruction stream with occasional flushes and bubbles.
        for (int n = 0; n < 60; n++) begin
            ctrl = codes[$urandom_range(0, 6)];
            fAt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 33)) : -1;
            runOp(ctrl, randOperand(), randOperand(), fAt);
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        idle(2);
        checkEn = 1'b0;
        $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
